// File: rtl/track_timer_reader_if.sv
// Memory read port and output record stream of the track-timestamp reader.
interface track_timer_reader_if;
   logic        rd_en;
   logic [15:0] rd_addr;
   logic [31:0] rd_data;
   logic        out_valid;
   logic        out_ready;
   logic [9:0]  out_index;
   logic [4:0]  out_bx;
   logic [26:0] out_delta;

   // Reader side: drives the memory strobe/address and the record stream
   modport master (
      output rd_en, rd_addr, out_valid, out_index, out_bx, out_delta,
      input  rd_data, out_ready
   );

   // Memory + consumer side
   modport slave (
      input  rd_en, rd_addr, out_valid, out_index, out_bx, out_delta,
      output rd_data, out_ready
   );
endinterface

// File: rtl/track_timer_reader.sv
// Walks the track-timestamp memory and streams each record's latency
// relative to record 0, with credit-based flow control into a small FWFT FIFO.
module track_timer_reader #(
   parameter int unsigned RD_LAT      = 2,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned MAX_RECORDS = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [10:0]           num_records,
   track_timer_reader_if.master  bus,
   output logic                  busy,
   output logic                  done,
   output logic                  order_err
);

   localparam int unsigned CNT_W  = 11;
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned OCC_W  = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned TS_W   = 27;
   localparam int unsigned BX_W   = 5;
   localparam int unsigned IDX_W  = 10;
   localparam int unsigned ADDR_W = 16;

   typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;

   typedef struct packed {
      logic [IDX_W-1:0] index;
      logic [BX_W-1:0]  bx;
      logic [TS_W-1:0]  delta;
   } rec_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    n_q, n_d;
   logic [CNT_W-1:0]    issued_q, issued_d;
   logic [CNT_W-1:0]    returned_q, returned_d;
   logic [CNT_W-1:0]    accepted_q, accepted_d;
   logic [OCC_W-1:0]    credit_q, credit_d;
   logic [OCC_W-1:0]    count_q, count_d;
   logic [PTR_W-1:0]    rptr_q, rptr_d;
   logic [PTR_W-1:0]    wptr_q, wptr_d;
   logic [RD_LAT-1:0]   dl_q, dl_d;
   logic [TS_W-1:0]     ref_q, ref_d;
   logic                rd_en_q, rd_en_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic                out_valid_q, out_valid_d;
   rec_t                head_q, head_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                order_err_q, order_err_d;
   rec_t                fifo_q [FIFO_DEPTH];

   logic                push_c;
   logic                pop_c;
   rec_t                push_rec_c;
   logic [OCC_W-1:0]    credit_eff_c;
   logic [CNT_W-1:0]    n_clamp_c;
   logic [TS_W-1:0]     ts_c;

   assign ts_c      = bus.rd_data[TS_W-1:0];
   assign n_clamp_c = (num_records > CNT_W'(MAX_RECORDS)) ? CNT_W'(MAX_RECORDS) : num_records;

   // Next-state, return path, FIFO bookkeeping and registered-output values
   always_comb begin
      state_d      = state_q;
      n_d          = n_q;
      issued_d     = issued_q;
      returned_d   = returned_q;
      accepted_d   = accepted_q;
      count_d      = count_q;
      rptr_d       = rptr_q;
      wptr_d       = wptr_q;
      dl_d         = RD_LAT'({dl_q, rd_en_q});
      ref_d        = ref_q;
      rd_en_d      = 1'b0;
      rd_addr_d    = rd_addr_q;
      out_valid_d  = out_valid_q;
      head_d       = head_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      order_err_d  = order_err_q;
      push_c       = dl_q[RD_LAT-1];
      pop_c        = out_valid_q & bus.out_ready;
      credit_eff_c = credit_q - OCC_W'(pop_c);
      credit_d     = credit_eff_c;

      // Returning word: record 0 becomes the reference, later ones saturate at 0 if early
      push_rec_c.index = IDX_W'(returned_q);
      push_rec_c.bx    = bus.rd_data[31:27];
      push_rec_c.delta = ((returned_q == '0) || (ts_c < ref_q)) ? '0 : (ts_c - ref_q);
      if (push_c) begin
         returned_d = returned_q + CNT_W'(1);
         if (returned_q == '0) begin
            ref_d = ts_c;
         end else if (ts_c < ref_q) begin
            order_err_d = 1'b1;
         end
      end

      // FWFT FIFO: head register tracks the entry that will be at the read pointer
      count_d     = count_q + OCC_W'(push_c) - OCC_W'(pop_c);
      rptr_d      = rptr_q + PTR_W'(pop_c);
      wptr_d      = wptr_q + PTR_W'(push_c);
      out_valid_d = (count_d != '0);
      if (count_d != '0) begin
         head_d = (push_c && (rptr_d == wptr_q)) ? push_rec_c : fifo_q[rptr_d];
      end

      unique case (state_q)
         IDLE: begin
            if (start) begin
               n_d         = n_clamp_c;
               issued_d    = '0;
               returned_d  = '0;
               accepted_d  = '0;
               credit_d    = '0;
               order_err_d = 1'b0;
               if (n_clamp_c == '0) begin
                  state_d = FINISH;
               end else begin
                  state_d   = STREAM;
                  busy_d    = 1'b1;
                  rd_en_d   = 1'b1;
                  rd_addr_d = '0;
                  issued_d  = CNT_W'(1);
                  credit_d  = OCC_W'(1);
               end
            end
         end
         STREAM: begin
            if ((issued_q < n_q) && (credit_eff_c < OCC_W'(FIFO_DEPTH))) begin
               rd_en_d   = 1'b1;
               rd_addr_d = ADDR_W'({issued_q, 2'b00});
               issued_d  = issued_q + CNT_W'(1);
               credit_d  = credit_eff_c + OCC_W'(1);
            end
            if (pop_c) begin
               accepted_d = accepted_q + CNT_W'(1);
               if ((accepted_q + CNT_W'(1)) == n_q) begin
                  state_d = FINISH;
                  done_d  = 1'b1;
               end
            end
         end
         FINISH: begin
            // STREAM arrives with done already raised; the empty pass raises it here
            busy_d  = 1'b0;
            done_d  = ~done_q;
            state_d = done_q ? IDLE : FINISH;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and control registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         n_q         <= '0;
         issued_q    <= '0;
         returned_q  <= '0;
         accepted_q  <= '0;
         credit_q    <= '0;
         count_q     <= '0;
         rptr_q      <= '0;
         wptr_q      <= '0;
         dl_q        <= '0;
         ref_q       <= '0;
         rd_en_q     <= 1'b0;
         rd_addr_q   <= '0;
         out_valid_q <= 1'b0;
         head_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         order_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         n_q         <= n_d;
         issued_q    <= issued_d;
         returned_q  <= returned_d;
         accepted_q  <= accepted_d;
         credit_q    <= credit_d;
         count_q     <= count_d;
         rptr_q      <= rptr_d;
         wptr_q      <= wptr_d;
         dl_q        <= dl_d;
         ref_q       <= ref_d;
         rd_en_q     <= rd_en_d;
         rd_addr_q   <= rd_addr_d;
         out_valid_q <= out_valid_d;
         head_q      <= head_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         order_err_q <= order_err_d;
      end
   end

   // FIFO storage
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fifo_q <= '{default: '0};
      end else if (push_c) begin
         fifo_q[wptr_q] <= push_rec_c;
      end
   end

   assign bus.rd_en     = rd_en_q;
   assign bus.rd_addr   = rd_addr_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_index = head_q.index;
   assign bus.out_bx    = head_q.bx;
   assign bus.out_delta = head_q.delta;
   assign busy          = busy_q;
   assign done          = done_q;
   assign order_err     = order_err_q;

endmodule

// File: tb/tb_track_timer_reader.sv
// Bench for track_timer_reader: three instances (RD_LAT 1,2,3) share stimulus
// and a timestamp memory; a record-level model checks every accepted output.
module tb_track_timer_reader;

   localparam int NL    = 3;
   localparam int MAIN  = 1;
   localparam int DEPTH = 4;

   logic               clk;
   logic               reset;
   logic               start;
   logic               out_ready;
   logic [10:0]        num_records;
   logic [NL-1:0]      ov, ren, busy_v, done_v, oe_v;
   logic [NL-1:0][9:0] oi;
   logic [NL-1:0][4:0] ob;
   logic [NL-1:0][26:0] od;
   logic [NL-1:0][15:0] raddr;

   logic [31:0] mem [1024];

   int checks;
   int failures;
   int cyc;

   int outst [NL];
   int max_outst [NL];
   int acc [NL];
   int exp_idx [NL];
   int last_addr [NL];
   int last_idx [NL];
   int done_cyc [NL];
   int last_acc_cyc [NL];
   bit done_seen [NL];
   bit oe_at_done [NL];

   typedef struct packed {
      logic [31:0] word;
      logic [4:0]  bx;
      logic [26:0] delta;
   } vec_t;
   vec_t tbl [4];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < NL; g++) begin : lane
      localparam int unsigned L = g + 1;
      track_timer_reader_if bus ();
      logic [31:0] pipe [L];

      track_timer_reader #(.RD_LAT(L), .FIFO_DEPTH(DEPTH), .MAX_RECORDS(1024)) dut (
         .clk         (clk),
         .reset       (reset),
         .start       (start),
         .num_records (num_records),
         .bus         (bus),
         .busy        (busy_v[g]),
         .done        (done_v[g]),
         .order_err   (oe_v[g])
      );

      // Memory with L cycles of read latency
      always @(posedge clk) begin
         pipe[0] <= bus.rd_en ? mem[bus.rd_addr[11:2]] : 32'hDEAD_BEEF;
         for (int j = 1; j < int'(L); j++) pipe[j] <= pipe[j-1];
      end

      assign bus.rd_data   = pipe[L-1];
      assign bus.out_ready = out_ready;
      assign ov[g]    = bus.out_valid;
      assign oi[g]    = bus.out_index;
      assign ob[g]    = bus.out_bx;
      assign od[g]    = bus.out_delta;
      assign ren[g]   = bus.rd_en;
      assign raddr[g] = bus.rd_addr;
   end

   function automatic logic [26:0] model_delta(int i);
      logic [26:0] r, t;
      r = mem[0][26:0];
      t = mem[i][26:0];
      return (i == 0 || t < r) ? 27'd0 : t - r;
   endfunction

   function automatic bit model_oe(int n);
      for (int i = 1; i < n; i++) if (mem[i][26:0] < mem[0][26:0]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic clear_lanes();
      for (int g = 0; g < NL; g++) begin
         outst[g] = 0; max_outst[g] = 0; acc[g] = 0; exp_idx[g] = 0;
         last_addr[g] = 0; last_idx[g] = 0; done_cyc[g] = -1;
         last_acc_cyc[g] = -1; done_seen[g] = 0; oe_at_done[g] = 0;
      end
   endtask

   // Observe all lanes at the falling edge, then advance one cycle
   task automatic step();
      @(negedge clk);
      if (!reset) begin
         for (int g = 0; g < NL; g++) begin
            if (ren[g]) begin
               outst[g]++;
               last_addr[g] = int'(raddr[g]);
            end
            if (ov[g] && out_ready) begin
               chk($sformatf("lane%0d_rec%0d", g, exp_idx[g]), 64'({oi[g], ob[g], od[g]}),
                   64'({10'(exp_idx[g]), mem[exp_idx[g]][31:27], model_delta(exp_idx[g])}));
               last_idx[g] = int'(oi[g]);
               acc[g]++;
               exp_idx[g]++;
               outst[g]--;
               last_acc_cyc[g] = cyc;
            end
            if (outst[g] > max_outst[g]) max_outst[g] = outst[g];
            if (done_v[g] && !done_seen[g]) begin
               done_seen[g]  = 1'b1;
               done_cyc[g]   = cyc;
               oe_at_done[g] = oe_v[g];
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic fill_mem(int n, bit err);
      logic [26:0] r, t, v;
      r = 27'($urandom_range(1000, 1 << 20));
      t = r;
      mem[0] = {5'($urandom), r};
      for (int i = 1; i < n; i++) begin
         if (err && (i == 1 || $urandom_range(0, 7) == 0)) begin
            v = r - 27'($urandom_range(1, 500));
         end else begin
            t = t + 27'($urandom_range(0, 300));
            v = t;
         end
         mem[i] = {5'($urandom), v};
      end
   endtask

   task automatic end_checks(int exp_n, bit exp_oe);
      for (int g = 0; g < NL; g++) begin
         chk($sformatf("lane%0d_count", g), 64'(acc[g]), 64'(exp_n));
         chk($sformatf("lane%0d_done_seen", g), 64'(done_seen[g]), 64'd1);
         chk($sformatf("lane%0d_done_after_last_accept", g), 64'(done_cyc[g]), 64'(last_acc_cyc[g] + 1));
         chk($sformatf("lane%0d_order_err_at_done", g), 64'(oe_at_done[g]), 64'(exp_oe));
         chk($sformatf("lane%0d_credit_bound", g), 64'(max_outst[g] <= DEPTH), 64'd1);
      end
   endtask

   // mode 0: ready high, 1: ready 1,0,0 repeating, 2: random ready
   task automatic run_pass(int n_in, int mode, bit glitch);
      int exp_n;
      int budget;
      exp_n = (n_in > 1024) ? 1024 : n_in;
      clear_lanes();
      num_records = 11'(n_in);
      out_ready   = 1'b1;
      cyc   = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("pass_c1_rd_en", 64'(ren[MAIN]), 64'd1);
      chk("pass_c1_rd_addr", 64'(raddr[MAIN]), 64'd0);
      chk("pass_c1_busy", 64'(busy_v[MAIN]), 64'd1);
      chk("pass_c1_order_err_cleared", 64'(oe_v), 64'd0);
      budget = 0;
      while (!(done_seen[0] && done_seen[1] && done_seen[2]) && budget < 5000) begin
         case (mode)
            1:       out_ready = (cyc % 3 == 1);
            2:       out_ready = ($urandom_range(0, 9) < 7);
            default: out_ready = 1'b1;
         endcase
         if (glitch && cyc == 2) begin
            start = 1'b1;
            num_records = 11'd3;
         end
         step();
         start = 1'b0;
         budget++;
         if (glitch && cyc == 3) begin
            chk("restart_ignored_addr", 64'({ren[MAIN], raddr[MAIN]}), 64'({1'b1, 16'd8}));
         end
      end
      chk("pass_done_within_budget", 64'(budget < 5000), 64'd1);
      out_ready = 1'b1;
      chk("pass_idle_after_done", 64'({busy_v, ov}), 64'd0);
      end_checks(exp_n, model_oe(exp_n));
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      bit exp_v;
      tbl[0] = '{word: {5'd3, 27'd100}, bx: 5'd3, delta: 27'd0};
      tbl[1] = '{word: {5'd4, 27'd150}, bx: 5'd4, delta: 27'd50};
      tbl[2] = '{word: {5'd4, 27'd151}, bx: 5'd4, delta: 27'd51};
      tbl[3] = '{word: {5'd7, 27'd400}, bx: 5'd7, delta: 27'd300};

      checks = 0; failures = 0; cyc = 0;
      reset = 1'b1; start = 1'b0; out_ready = 1'b1; num_records = '0;
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      clear_lanes();
      repeat (2) @(posedge clk);
      #1;
      for (int g = 0; g < NL; g++) begin
         chk($sformatf("lane%0d_reset_state", g),
             64'({ov[g], oi[g], ob[g], od[g], ren[g], raddr[g], busy_v[g], done_v[g], oe_v[g]}), 64'd0);
      end
      reset = 1'b0;
      step();

      // Basic pass, swept over all three latencies in parallel
      clear_lanes();
      for (int i = 0; i < 4; i++) mem[i] = tbl[i].word;
      num_records = 11'd4;
      cyc = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         for (int g = 0; g < NL; g++) begin
            k = c - (g + 3);
            exp_v = (k >= 0 && k < 4);
            chk($sformatf("basic_lane%0d_valid_c%0d", g, c), 64'(ov[g]), 64'(exp_v));
            if (exp_v) begin
               chk($sformatf("basic_lane%0d_out_c%0d", g, c), 64'({oi[g], ob[g], od[g]}),
                   64'({10'(k), tbl[k].bx, tbl[k].delta}));
            end
            chk($sformatf("basic_lane%0d_done_c%0d", g, c), 64'(done_v[g]), 64'(c == g + 7));
            chk($sformatf("basic_lane%0d_busy_c%0d", g, c), 64'(busy_v[g]), 64'(c <= g + 7));
         end
         chk($sformatf("basic_rd_en_c%0d", c), 64'(ren[MAIN]), 64'(c <= 4));
         if (c <= 4) chk($sformatf("basic_rd_addr_c%0d", c), 64'(raddr[MAIN]), 64'(4 * (c - 1)));
         step();
      end
      end_checks(4, 1'b0);

      // Empty pass
      clear_lanes();
      num_records = 11'd0;
      cyc = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         chk($sformatf("n0_rd_en_c%0d", c), 64'(ren), 64'd0);
         chk($sformatf("n0_busy_c%0d", c), 64'(busy_v), 64'd0);
         chk($sformatf("n0_done_c%0d", c), 64'(done_v), (c == 2) ? 64'd7 : 64'd0);
         step();
      end

      // Order error: word1 earlier than the reference
      mem[0] = {5'd1, 27'd100};
      mem[1] = {5'd2, 27'd50};
      mem[2] = {5'd3, 27'd120};
      run_pass(3, 0, 1'b0);
      chk("order_err_held_after_done", 64'(oe_v), 64'd7);

      // Clean pass must clear the sticky flag on start
      fill_mem(6, 1'b0);
      run_pass(6, 0, 1'b0);

      // Backpressure
      fill_mem(16, 1'b0);
      run_pass(16, 1, 1'b0);

      // Start while streaming is ignored
      fill_mem(8, 1'b0);
      run_pass(8, 0, 1'b1);

      // Asynchronous reset in the middle of a pass
      fill_mem(16, 1'b1);
      clear_lanes();
      num_records = 11'd16;
      cyc = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      while (cyc < 6) begin
         out_ready = (cyc % 3 == 1);
         step();
      end
      chk("midpass_order_err_set", 64'(oe_v[MAIN]), 64'd1);
      #2;
      reset = 1'b1;
      #1;
      for (int g = 0; g < NL; g++) begin
         chk($sformatf("lane%0d_async_reset_outputs", g),
             64'({ov[g], oi[g], ob[g], od[g], ren[g], raddr[g], busy_v[g], done_v[g], oe_v[g]}), 64'd0);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      out_ready = 1'b1;
      run_pass(5, 0, 1'b0);

      // Randomised passes against the record model
      for (int r = 0; r < 6; r++) begin
         int n;
         n = $urandom_range(1, 40);
         fill_mem(n, r[0]);
         run_pass(n, 2, 1'b0);
      end

      // Count clamp
      fill_mem(1024, 1'b0);
      run_pass(2000, 0, 1'b0);
      for (int g = 0; g < NL; g++) begin
         chk($sformatf("lane%0d_clamp_last_addr", g), 64'(last_addr[g]), 64'h0FFC);
         chk($sformatf("lane%0d_clamp_last_index", g), 64'(last_idx[g]), 64'd1023);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
